// File: rtl/pe_feeder_pkg.sv
// Shared definitions for the PE stream feeder: channel state encoding and
// positions of the start/end frame bits above the data word.
package pe_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } chan_state_e;

    localparam int DEFAULT_WIDTH = 4;
    localparam int START_BIT     = DEFAULT_WIDTH + 1;
    localparam int END_BIT       = DEFAULT_WIDTH;

    function automatic int start_bit(input int width);
        return width + 1;
    endfunction

    function automatic int end_bit(input int width);
        return width;
    endfunction

endpackage

// File: rtl/pe_feeder_channel.sv
// One feeder stream: issues source-memory reads, stages returned words in a
// 2-entry FIFO and pushes them into a PE buffer under its ready signal.
module pe_feeder_channel
    import pe_feeder_pkg::*;
#(
    parameter int WIDTH          = 4,
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int LEN_WIDTH      = 8,
    parameter bit FRAME          = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [MEM_ADDR_WIDTH-1:0] base,
    input  logic [LEN_WIDTH-1:0]      len,
    input  logic                      job_done,
    output logic                      mem_ren,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    input  logic [WIDTH-1:0]          mem_rdata,
    input  logic                      ready,
    output logic                      write_en,
    output logic [WIDTH+1:0]          word,
    output logic                      finishing,
    output logic                      stall,
    output chan_state_e               state
);

    localparam int SB = start_bit(WIDTH);
    localparam int EB = end_bit(WIDTH);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    logic [MEM_ADDR_WIDTH-1:0] base_q;
    logic [LEN_WIDTH-1:0]      len_q;
    logic [LEN_WIDTH-1:0]      issued;
    logic                      in_flight;
    logic [1:0]                flight_tag;
    logic [WIDTH+1:0]          fifo_mem [2];
    logic                      wr_ptr;
    logic                      rd_ptr;
    logic [1:0]                count;
    logic [1:0]                occ_after_pop;
    logic                      pop;
    logic                      is_first;
    logic                      is_last;
    logic                      last_read;
    logic                      last_push;
    logic [WIDTH+1:0]          entry;

    // Occupancy is judged after this cycle's pop so a steady stream keeps
    // one word staged and one in flight without bubbles.
    assign pop           = (count != 2'd0) && ready;
    assign occ_after_pop = count - {1'b0, pop} + {1'b0, in_flight};
    assign mem_ren       = (state == RUN) && (occ_after_pop < 2'd2);
    assign mem_addr      = mem_ren ? (base_q + MEM_ADDR_WIDTH'(issued)) : '0;

    assign is_first  = (issued == '0);
    assign is_last   = (issued == len_q - LEN_ONE);
    assign last_read = mem_ren && is_last;
    assign last_push = (state == DRAIN) && !in_flight && (count == 2'd1) && pop;

    assign write_en  = pop;
    assign word      = pop ? fifo_mem[rd_ptr] : '0;
    assign finishing = (state == FIN) || last_push;
    assign stall     = (count != 2'd0) && !ready;

    always_comb begin
        entry            = '0;
        entry[WIDTH-1:0] = mem_rdata;
        entry[SB]        = flight_tag[1];
        entry[EB]        = flight_tag[0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            base_q      <= '0;
            len_q       <= '0;
            issued      <= '0;
            in_flight   <= 1'b0;
            flight_tag  <= 2'b00;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
        end else begin
            in_flight  <= mem_ren;
            flight_tag <= FRAME ? {is_first, is_last} : 2'b00;
            if (mem_ren) begin
                issued <= issued + LEN_ONE;
            end
            if (in_flight) begin
                fifo_mem[wr_ptr] <= entry;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, in_flight} - {1'b0, pop};

            case (state)
                IDLE: begin
                    if (start) begin
                        base_q <= base;
                        len_q  <= len;
                        issued <= '0;
                        state  <= (len == '0) ? FIN : RUN;
                    end
                end
                RUN: begin
                    if (last_read) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_push) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    if (job_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pe_stream_feeder.sv
// PE stream feeder top: accepts jobs and runs a framed ifmap channel and a raw
// filter channel in parallel. FEEDER_PERF_EN adds the stall_cycles counter.
module pe_stream_feeder
    import pe_feeder_pkg::*;
#(
    parameter int WIDTH          = 4,
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int LEN_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      job_start,
    input  logic [MEM_ADDR_WIDTH-1:0] ifmap_base,
    input  logic [LEN_WIDTH-1:0]      ifmap_len,
    input  logic [MEM_ADDR_WIDTH-1:0] filter_base,
    input  logic [LEN_WIDTH-1:0]      filter_len,
    output logic                      ifmap_mem_ren,
    output logic [MEM_ADDR_WIDTH-1:0] ifmap_mem_addr,
    input  logic [WIDTH-1:0]          ifmap_mem_rdata,
    output logic                      filter_mem_ren,
    output logic [MEM_ADDR_WIDTH-1:0] filter_mem_addr,
    input  logic [WIDTH-1:0]          filter_mem_rdata,
    input  logic                      ready_ifmap_buf,
    output logic                      write_en_ifmap,
    output logic [WIDTH+1:0]          ifmap_buffer_inp,
    input  logic                      ready_filter_buf,
    output logic                      write_en_filter,
    output logic [WIDTH-1:0]          filter_buffer_inp,
    output logic                      busy,
    output logic                      done,
    output logic                      job_err
`ifdef FEEDER_PERF_EN
    ,
    output logic [15:0]               stall_cycles
`endif
);

    logic        accept;
    logic        done_next;
    logic        ifmap_fin;
    logic        filter_fin;
    logic        ifmap_stall;
    logic        filter_stall;
    logic [WIDTH+1:0] filter_word;
    chan_state_e ifmap_state;
    chan_state_e filter_state;
    logic        unused_taps;

    // The done cycle is excluded so a new job never overlaps channels still in FIN.
    assign accept    = job_start && !busy && !done;
    assign done_next = busy && ifmap_fin && filter_fin;

    pe_feeder_channel #(
        .WIDTH(WIDTH), .MEM_ADDR_WIDTH(MEM_ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH), .FRAME(1'b1)
    ) u_ifmap (
        .clk(clk), .rst(rst), .start(accept), .base(ifmap_base), .len(ifmap_len),
        .job_done(done), .mem_ren(ifmap_mem_ren), .mem_addr(ifmap_mem_addr),
        .mem_rdata(ifmap_mem_rdata), .ready(ready_ifmap_buf), .write_en(write_en_ifmap),
        .word(ifmap_buffer_inp), .finishing(ifmap_fin), .stall(ifmap_stall),
        .state(ifmap_state)
    );

    pe_feeder_channel #(
        .WIDTH(WIDTH), .MEM_ADDR_WIDTH(MEM_ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH), .FRAME(1'b0)
    ) u_filter (
        .clk(clk), .rst(rst), .start(accept), .base(filter_base), .len(filter_len),
        .job_done(done), .mem_ren(filter_mem_ren), .mem_addr(filter_mem_addr),
        .mem_rdata(filter_mem_rdata), .ready(ready_filter_buf), .write_en(write_en_filter),
        .word(filter_word), .finishing(filter_fin), .stall(filter_stall),
        .state(filter_state)
    );

    assign filter_buffer_inp = filter_word[WIDTH-1:0];
    assign unused_taps = ^{filter_word[WIDTH+1:WIDTH], ifmap_state, filter_state};

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            job_err <= 1'b0;
        end else begin
            done    <= done_next;
            job_err <= job_start && busy;
            if (accept) begin
                busy <= 1'b1;
            end else if (done_next) begin
                busy <= 1'b0;
            end
        end
    end

`ifdef FEEDER_PERF_EN
    logic [16:0] stall_sum;

    assign stall_sum = {1'b0, stall_cycles} + {16'd0, ifmap_stall} + {16'd0, filter_stall};

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles <= 16'd0;
        end else if (accept) begin
            stall_cycles <= 16'd0;
        end else begin
            stall_cycles <= stall_sum[16] ? 16'hFFFF : stall_sum[15:0];
        end
    end
`else
    logic unused_stall;
    assign unused_stall = ifmap_stall ^ filter_stall;
`endif

endmodule

// File: tb/tb_pe_stream_feeder.sv
// Bench for pe_stream_feeder: directed framing/wrap/back-pressure/error/reset
// cases plus random jobs, checked by a queue scoreboard from a word-list model.
module tb_pe_stream_feeder;

    localparam int W  = 4;
    localparam int AW = 8;
    localparam int LW = 8;

    logic          clk;
    logic          rst;
    logic          job_start;
    logic [AW-1:0] ifmap_base;
    logic [LW-1:0] ifmap_len;
    logic [AW-1:0] filter_base;
    logic [LW-1:0] filter_len;
    logic          ifmap_mem_ren;
    logic [AW-1:0] ifmap_mem_addr;
    logic [W-1:0]  ifmap_mem_rdata;
    logic          filter_mem_ren;
    logic [AW-1:0] filter_mem_addr;
    logic [W-1:0]  filter_mem_rdata;
    logic          ready_ifmap_buf;
    logic          write_en_ifmap;
    logic [W+1:0]  ifmap_buffer_inp;
    logic          ready_filter_buf;
    logic          write_en_filter;
    logic [W-1:0]  filter_buffer_inp;
    logic          busy;
    logic          done;
    logic          job_err;
`ifdef FEEDER_PERF_EN
    logic [15:0]   stall_cycles;
`endif

    logic [W-1:0]  imem [256];
    logic [W-1:0]  fmem [256];
    logic [W+1:0]  exp_if_q [$];
    logic [W-1:0]  exp_fl_q [$];
    logic [AW-1:0] exp_if_addr_q [$];
    logic [AW-1:0] exp_fl_addr_q [$];

    int total;
    int bad;
    int cyc;
    int start_cyc;
    int if_wr_cnt;
    int fl_wr_cnt;
    int err_cnt;
    bit rdy_rand;

    logic          m_if_ren;
    logic          m_fl_ren;
    logic [AW-1:0] m_if_addr;
    logic [AW-1:0] m_fl_addr;
    logic [W+1:0]  mon_if;
    logic [W-1:0]  mon_fl;
    logic [AW-1:0] mon_addr;

    pe_stream_feeder #(.WIDTH(W), .MEM_ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .job_start(job_start),
        .ifmap_base(ifmap_base), .ifmap_len(ifmap_len),
        .filter_base(filter_base), .filter_len(filter_len),
        .ifmap_mem_ren(ifmap_mem_ren), .ifmap_mem_addr(ifmap_mem_addr),
        .ifmap_mem_rdata(ifmap_mem_rdata),
        .filter_mem_ren(filter_mem_ren), .filter_mem_addr(filter_mem_addr),
        .filter_mem_rdata(filter_mem_rdata),
        .ready_ifmap_buf(ready_ifmap_buf), .write_en_ifmap(write_en_ifmap),
        .ifmap_buffer_inp(ifmap_buffer_inp),
        .ready_filter_buf(ready_filter_buf), .write_en_filter(write_en_filter),
        .filter_buffer_inp(filter_buffer_inp),
        .busy(busy), .done(done), .job_err(job_err)
`ifdef FEEDER_PERF_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    // clock / cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // source memories with one-cycle read latency; idle cycles return noise
    initial begin
        ifmap_mem_rdata  = '0;
        filter_mem_rdata = '0;
        forever begin
            @(posedge clk);
            m_if_ren  = ifmap_mem_ren;
            m_if_addr = ifmap_mem_addr;
            m_fl_ren  = filter_mem_ren;
            m_fl_addr = filter_mem_addr;
            #1;
            ifmap_mem_rdata  = m_if_ren ? imem[m_if_addr] : W'($urandom);
            filter_mem_rdata = m_fl_ren ? fmem[m_fl_addr] : W'($urandom);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) begin
                ready_ifmap_buf  = ($urandom_range(0, 9) < 7);
                ready_filter_buf = ($urandom_range(0, 9) < 6);
            end
        end
    end

    // monitor: every write and read strobe is matched against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (write_en_ifmap) begin
                if_wr_cnt++;
                check("if_wr_ready", ready_ifmap_buf, 1);
                if (exp_if_q.size() == 0) check("if_wr_extra", 1, 0);
                else begin
                    mon_if = exp_if_q.pop_front();
                    check("if_word", ifmap_buffer_inp, mon_if);
                end
            end
            if (write_en_filter) begin
                fl_wr_cnt++;
                check("fl_wr_ready", ready_filter_buf, 1);
                if (exp_fl_q.size() == 0) check("fl_wr_extra", 1, 0);
                else begin
                    mon_fl = exp_fl_q.pop_front();
                    check("fl_word", filter_buffer_inp, mon_fl);
                end
            end
            if (ifmap_mem_ren) begin
                if (exp_if_addr_q.size() == 0) check("if_rd_extra", 1, 0);
                else begin
                    mon_addr = exp_if_addr_q.pop_front();
                    check("if_addr", ifmap_mem_addr, mon_addr);
                end
            end
            if (filter_mem_ren) begin
                if (exp_fl_addr_q.size() == 0) check("fl_rd_extra", 1, 0);
                else begin
                    mon_addr = exp_fl_addr_q.pop_front();
                    check("fl_addr", filter_mem_addr, mon_addr);
                end
            end
            if (job_err) err_cnt++;
        end
    end

    // driver tasks
    task automatic fill_mems();
        for (int i = 0; i < 256; i++) begin
            imem[i] = W'($urandom);
            fmem[i] = W'($urandom);
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        job_start = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_ctrl", {ifmap_mem_ren, filter_mem_ren, write_en_ifmap, write_en_filter,
                           busy, done, job_err}, 0);
        check("rst_addr", {ifmap_mem_addr, filter_mem_addr}, 0);
        check("rst_data", {ifmap_buffer_inp, filter_buffer_inp}, 0);
`ifdef FEEDER_PERF_EN
        check("rst_stall", stall_cycles, 0);
`endif
        exp_if_q.delete();
        exp_fl_q.delete();
        exp_if_addr_q.delete();
        exp_fl_addr_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic issue_job(input logic [AW-1:0] ib, input int il,
                             input logic [AW-1:0] fb, input int fl);
        @(posedge clk);
        #1;
        job_start   = 1'b1;
        ifmap_base  = ib;
        ifmap_len   = LW'(il);
        filter_base = fb;
        filter_len  = LW'(fl);
        if_wr_cnt   = 0;
        fl_wr_cnt   = 0;
        // reference: word i of a stream lives at base+i, first/last ifmap words framed
        for (int i = 0; i < il; i++) begin
            exp_if_addr_q.push_back(AW'(ib + i));
            exp_if_q.push_back({(i == 0), (i == il - 1), imem[AW'(ib + i)]});
        end
        for (int i = 0; i < fl; i++) begin
            exp_fl_addr_q.push_back(AW'(fb + i));
            exp_fl_q.push_back(fmem[AW'(fb + i)]);
        end
        @(posedge clk);
        #1;
        start_cyc   = cyc;
        job_start   = 1'b0;
        ifmap_base  = AW'($urandom);
        ifmap_len   = LW'($urandom);
        filter_base = AW'($urandom);
        filter_len  = LW'($urandom);
    endtask

    task automatic wait_done(input int il, input int fl, output int lat);
        bit seen;
        seen = 1'b0;
        lat = -1;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                lat = cyc - start_cyc;
            end
        end
        check("done_seen", seen, 1);
        check("busy_at_done", busy, 0);
        check("if_left", exp_if_q.size() + exp_if_addr_q.size(), 0);
        check("fl_left", exp_fl_q.size() + exp_fl_addr_q.size(), 0);
        check("if_wr_cnt", if_wr_cnt, il);
        check("fl_wr_cnt", fl_wr_cnt, fl);
    endtask

    task automatic run_job(input logic [AW-1:0] ib, input int il,
                           input logic [AW-1:0] fb, input int fl, output int lat);
        issue_job(ib, il, fb, fl);
        wait_done(il, fl, lat);
    endtask

    int lat;
    int ren_stall;
    int il_r;
    int fl_r;

    initial begin
        total = 0;
        bad = 0;
        err_cnt = 0;
        rdy_rand = 1'b0;
        rst = 1'b0;
        job_start = 1'b0;
        ifmap_base = '0;
        ifmap_len = '0;
        filter_base = '0;
        filter_len = '0;
        ready_ifmap_buf = 1'b1;
        ready_filter_buf = 1'b1;
        fill_mems();
        apply_reset();

        // basic framing and latency
        run_job(AW'($urandom), 4, AW'($urandom), 3, lat);
        check("lat_4_3", lat, 6);

        // single-word ifmap, empty filter
        run_job(AW'($urandom), 1, AW'($urandom), 0, lat);
        check("lat_1_0", lat, 3);

        // address wrap
        run_job(8'hFE, 4, 8'hFF, 2, lat);
        check("lat_wrap", lat, 6);

        // ifmap back-pressure for five cycles
        issue_job(AW'($urandom), 8, AW'($urandom), 2);
        repeat (3) @(posedge clk);
        #1;
        ready_ifmap_buf = 1'b0;
        ren_stall = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k >= 1 && ifmap_mem_ren) ren_stall++;
        end
        @(posedge clk);
        #1;
        ready_ifmap_buf = 1'b1;
        check("stall_no_reads", ren_stall, 0);
        wait_done(8, 2, lat);
`ifdef FEEDER_PERF_EN
        check("stall_cycles", stall_cycles, 5);
`endif

        // job_start while busy
        err_cnt = 0;
        issue_job(AW'($urandom), 6, AW'($urandom), 6);
        job_start = 1'b1;
        ifmap_len = 8'd3;
        @(posedge clk);
        #1;
        job_start = 1'b0;
        @(negedge clk);
        check("job_err_pulse", job_err, 1);
        wait_done(6, 6, lat);
        check("job_err_cnt", err_cnt, 1);

        // reset in the middle of a job, then a clean job
        issue_job(AW'($urandom), 10, AW'($urandom), 10);
        repeat (4) @(posedge clk);
        apply_reset();
        run_job(AW'($urandom), 5, AW'($urandom), 7, lat);
        check("lat_after_rst", lat, 9);

        // random jobs under random back-pressure
        rdy_rand = 1'b1;
        for (int j = 0; j < 20; j++) begin
            fill_mems();
            il_r = $urandom_range(0, 12);
            fl_r = $urandom_range(0, 12);
            run_job(AW'($urandom), il_r, AW'($urandom), fl_r, lat);
        end
        rdy_rand = 1'b0;
        @(posedge clk);
        #1;
        ready_ifmap_buf = 1'b1;
        ready_filter_buf = 1'b1;

        repeat (3) @(negedge clk);
        check("final_idle", {busy, done, write_en_ifmap, write_en_filter}, 0);

        // report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
